// File: rtl/fw_image_reader_if.sv
// SD sector bus toward hps_io plus the byte-stream handshake toward the flasher.
// The reader owns the master side; hps_io and the downstream consumer sit on the slave side.
interface fw_image_reader_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output sd_lba, sd_rd, sd_buff_din, out_data, out_valid, out_last,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, out_ready
  );

  modport slave (
    input  sd_lba, sd_rd, sd_buff_din, out_data, out_valid, out_last,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, out_ready
  );
endinterface

// File: rtl/fw_image_reader.sv
// Streams a mounted firmware image out of hps_io, one buffered 512 B sector at a time,
// as a valid/ready byte stream; the final partial sector is trimmed to the image size.
module fw_image_reader #(
  parameter logic [31:0] MAX_SIZE    = 32'h0010_0000,
  parameter logic [23:0] ACK_TIMEOUT = 24'd5_000_000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              img_mounted,
  input  logic [63:0]       img_size,
  input  logic              start,
  input  logic              abort,
  fw_image_reader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       bytes_sent
);
  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_ACK, XFER, DRAIN, ABORT_WAIT, DONE, ERR
  } state_t;

  state_t      state, state_d;
  logic [31:0] size_q;
  logic        oversize;
  logic [31:0] lba;
  logic [23:0] tmo_cnt;
  logic [9:0]  rd_idx;
  logic        ack_q;
  logic        out_valid_q;
  logic [7:0]  mem [512];
  logic [7:0]  mem_q;

  logic        ack_rise, ack_fall, accept, last_byte, abort_req, buf_we;
  logic        clear_run, next_sector, valid_d;
  logic [40:0] remaining;
  logic [9:0]  sect_len, rd_idx_n;
  logic [8:0]  rd_addr;

  assign ack_rise  = bus.sd_ack & ~ack_q;
  assign ack_fall  = ~bus.sd_ack & ack_q;
  assign accept    = out_valid_q & bus.out_ready;
  assign last_byte = (bytes_sent == size_q - 32'd1);
  assign abort_req = abort | (img_mounted & busy);
  assign buf_we    = bus.sd_buff_wr & bus.sd_ack & ((state == WAIT_ACK) | (state == XFER));

  // 41-bit byte offset of the current sector so lba*512 never wraps
  assign remaining = {9'd0, size_q} - {lba, 9'd0};
  assign sect_len  = (remaining >= 41'd512) ? 10'd512 : remaining[9:0];
  assign rd_idx_n  = rd_idx + {9'd0, accept};
  // Read ahead to the byte that will be on out_data next cycle, giving one byte per clock
  assign rd_addr   = rd_idx[8:0] + {8'd0, accept};

  always_comb begin
    state_d     = state;
    clear_run   = 1'b0;
    next_sector = 1'b0;
    valid_d     = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (abort_req) begin
          state_d = IDLE;
        end else if (start) begin
          if (size_q == 32'd0 || oversize) begin
            state_d = ERR;
          end else begin
            state_d   = REQ;
            clear_run = 1'b1;
          end
        end
      end
      REQ:      state_d = abort_req ? IDLE : WAIT_ACK;
      WAIT_ACK: begin
        if (abort_req)                             state_d = ABORT_WAIT;
        else if (ack_rise)                         state_d = XFER;
        else if (tmo_cnt == ACK_TIMEOUT - 24'd1)   state_d = ERR;
      end
      XFER: begin
        if (abort_req)     state_d = ABORT_WAIT;
        else if (ack_fall) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort_req) begin
          state_d = IDLE;
        end else if (accept && last_byte) begin
          state_d = DONE;
        end else if (rd_idx_n == sect_len) begin
          state_d     = REQ;
          next_sector = 1'b1;
        end else begin
          valid_d = 1'b1;
        end
      end
      ABORT_WAIT: if (!bus.sd_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      size_q      <= 32'd0;
      oversize    <= 1'b0;
      lba         <= 32'd0;
      tmo_cnt     <= 24'd0;
      rd_idx      <= 10'd0;
      ack_q       <= 1'b0;
      out_valid_q <= 1'b0;
      mem_q       <= 8'd0;
      bytes_sent  <= 32'd0;
    end else begin
      state       <= state_d;
      ack_q       <= bus.sd_ack;
      out_valid_q <= valid_d;
      mem_q       <= mem[rd_addr];
      tmo_cnt     <= (state == WAIT_ACK) ? tmo_cnt + 24'd1 : 24'd0;
      rd_idx      <= (state == DRAIN) ? rd_idx_n : 10'd0;
      if (img_mounted) begin
        size_q   <= img_size[31:0];
        oversize <= (img_size > {32'd0, MAX_SIZE});
      end
      if (clear_run) begin
        lba        <= 32'd0;
        bytes_sent <= 32'd0;
      end else begin
        if (next_sector) lba <= lba + 32'd1;
        if (accept)      bytes_sent <= bytes_sent + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (buf_we) mem[bus.sd_buff_addr] <= bus.sd_buff_dout;
  end

  assign bus.sd_lba      = lba;
  assign bus.sd_rd       = (state == WAIT_ACK);
  assign bus.sd_buff_din = 8'd0;
  assign bus.out_data    = mem_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_valid_q & last_byte;
  assign busy            = !(state == IDLE || state == DONE || state == ERR);
  assign done            = (state == DONE);
  assign error           = (state == ERR);
endmodule

// File: doc/fw_image_reader.md
Name: fw_image_reader

Overview:
Reads the mounted firmware image from the hps_io SD block interface (sector-based, 512 B) and presents it to the downstream flasher/UART stage as a byte stream with a valid/ready handshake. It tracks image size, issues sequential sector reads, buffers one sector, and trims the final partial sector. It sits between hps_io (SD signals) and the STM32 flash protocol engine inside system.

Parameters:
MAX_SIZE, 32'h0010_0000, largest accepted image in bytes; a larger image raises error.
ACK_TIMEOUT, 24'd5_000_000, clk_sys cycles allowed between sd_rd assertion and sd_ack rise.

Ports:
clk_sys  input  1  system clock
reset  input  1  asynchronous, active-high reset
img_mounted  input  1  pulse: new image mounted; latch img_size
img_size  input  64  image size in bytes, valid with img_mounted
start  input  1  single-cycle pulse: begin streaming from offset 0
abort  input  1  single-cycle pulse: stop streaming and return to idle
sd_lba  output  32  sector address for the current read
sd_rd  output  1  read request to hps_io
sd_ack  input  1  hps_io transfer-active flag
sd_buff_addr  input  9  byte index within the sector
sd_buff_dout  input  8  sector byte from hps_io
sd_buff_wr  input  1  write strobe for sd_buff_dout
sd_buff_din  output  8  tied to 0 (read-only block)
out_data  output  8  stream byte
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts the byte when out_valid and out_ready are both high
out_last  output  1  high with the final image byte
busy  output  1  high in every state except IDLE, DONE, ERR
done  output  1  held high in DONE
error  output  1  held high in ERR
bytes_sent  output  32  count of accepted bytes

Behaviour:
- Reset values: every output is 0. State goes to IDLE. The latched size is 0.
- img_mounted latches size = img_size[31:0]. The latch is flagged oversize if img_size > MAX_SIZE.
- If img_mounted arrives while busy, it acts as abort and also latches the new size.
- States: IDLE, REQ, WAIT_ACK, XFER, DRAIN, ABORT_WAIT, DONE, ERR.
- IDLE, DONE and ERR all respond to start:
  - If size == 0 or the oversize flag is set, go to ERR.
  - Otherwise clear lba, byte offset and bytes_sent, then go to REQ.
- REQ:
  - Drive sd_lba = lba and set sd_rd = 1.
  - Go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK:
  - sd_rd stays 1.
  - When sd_ack rises, clear sd_rd and go to XFER.
  - If the counter reaches ACK_TIMEOUT, clear sd_rd and go to ERR.
- XFER:
  - Each sd_buff_wr writes sd_buff_dout into a 512x8 buffer at sd_buff_addr.
  - The falling edge of sd_ack moves to DRAIN with rd_idx = 0.
- DRAIN:
  - The buffer read has 1-cycle latency. out_data comes from a prefetch register, so when out_ready is held high the throughput is one byte per clock.
  - sect_len = min(512, size - lba*512).
  - On each accept: increment bytes_sent and rd_idx.
  - out_last = 1 when bytes_sent == size - 1.
  - On the accept with out_last = 1, go to DONE.
  - Otherwise, when rd_idx reaches sect_len: lba <= lba + 1 and go to REQ. out_valid falls in the same cycle.
- Handshake: out_data and out_last must stay stable while out_valid = 1 and out_ready = 0. out_valid never drops without an accept, except on abort or reset.
- Abort:
  - From IDLE, DONE, ERR, REQ or DRAIN: go to IDLE, with out_valid and sd_rd = 0 on the next cycle.
  - From WAIT_ACK or XFER: go to ABORT_WAIT, which holds sd_rd = 0 until sd_ack = 0, then goes to IDLE.
  - If start and abort arrive together, abort wins.
- Arithmetic: the 32-bit size gives a maximum of 8M sectors. The lba compare uses a 41-bit product so it cannot overflow.
- Reset mid-operation drops sd_rd immediately (asynchronous). Any hps_io transfer still in progress is ignored.

Test Plan:
- Mount size=1024, start, hps_io model acks LBA0 then LBA1, out_ready=1 -> 1024 bytes in order, out_last on byte 1023, done=1, bytes_sent=1024, sd_lba sequence 0 then 1.
- Mount size=700 -> two reads; the second sector drains only 188 bytes; out_last on byte 699; no third sd_rd.
- Size=600 with out_ready toggling 1-0-0-1 -> no bytes lost or duplicated; out_data stable while stalled; output matches a reference pattern byte-for-byte.
- size=0, and separately img_size=MAX_SIZE+1, then start -> error=1 within 2 cycles; sd_rd never asserted.
- hps_io model never acks -> sd_rd high for exactly ACK_TIMEOUT cycles, then sd_rd=0 and error=1; a new start then retries from LBA0.
- Abort during XFER with sd_ack high for 100 more cycles -> state holds in ABORT_WAIT; busy=1 until sd_ack falls, then IDLE; out_valid never asserts. Also assert reset mid-DRAIN -> all outputs 0 immediately.
